// File: rtl/prefetch_feeder_pkg.sv
// Shared definitions for the prefetch feeder.
//   feeder_state_t : run state of the feeder (STOPPED / RUNNING)
//   occ_bits()     : width needed to count 0..depth words held in the FIFO
package prefetch_feeder_pkg;

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } feeder_state_t;

    function automatic int occ_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prefetch_feeder_updown.sv
// Up/down counter with synchronous load, used for the feeder's occupancy,
// pending and discard counts.
//   clk, reset : clock and synchronous active-high reset (clears to 0)
//   inc, dec   : count up / down by one; both together hold the value
//   load       : replace the count with load_value (wins over inc/dec)
//   count      : current registered count
module updown_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (inc && !dec) begin
            count_next = count_reg + ONE;
        end else if (dec && !inc) begin
            count_next = count_reg - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/prefetch_feeder.sv
// Prefetch feeder: issues sequential word reads to memory and pushes each
// returned word into a small downstream FIFO. Requests are only issued while
// a FIFO slot is guaranteed for the answer, so the FIFO can never overflow.
// A redirect reloads the fetch address, clears the FIFO and turns every
// in-flight response into a discard.
//   clk, reset                     : clock, synchronous active-high reset
//   redirect, redirect_addr        : jump to a new fetch address, start running
//   stop                           : stop issuing requests (in-flight still land)
//   mem_req_valid/ready/addr       : request channel (addr is registered)
//   mem_resp_valid/data            : in-order response channel
//   fifo_add, fifo_new_entry       : push port of the downstream FIFO
//   fifo_remove                    : consumer's pop of the downstream FIFO
//   fifo_clear                     : FIFO reset (reset | redirect)
//   occupancy                      : words currently held in the FIFO
module prefetch_feeder
    import prefetch_feeder_pkg::*;
#(
    parameter int ADDR_BITS       = 16,
    parameter int DATA_BITS       = 16,
    parameter int FIFO_DEPTH      = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            redirect,
    input  logic [ADDR_BITS-1:0]            redirect_addr,
    input  logic                            stop,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [ADDR_BITS-1:0]            mem_req_addr,
    input  logic                            mem_resp_valid,
    input  logic [DATA_BITS-1:0]            mem_resp_data,
    output logic                            fifo_add,
    output logic [DATA_BITS-1:0]            fifo_new_entry,
    input  logic                            fifo_remove,
    output logic                            fifo_clear,
    output logic [occ_bits(FIFO_DEPTH)-1:0] occupancy
);

    localparam int OCC_W  = occ_bits(FIFO_DEPTH);
    localparam int PEND_W = $clog2(MAX_OUTSTANDING + 1);
    // One spare bit so the credit arithmetic has headroom whichever count is wider.
    localparam int FREE_W = ((OCC_W > PEND_W) ? OCC_W : PEND_W) + 1;

    feeder_state_t state_reg;
    feeder_state_t state_next;

    logic [ADDR_BITS-1:0] addr_reg;
    logic [OCC_W-1:0]     occ;
    logic [PEND_W-1:0]    pending;
    logic [PEND_W-1:0]    discard;
    logic [PEND_W-1:0]    discard_load;

    logic [FREE_W-1:0]    free;
    logic                 credit_ok;
    logic                 below_max;
    logic                 handshake;
    logic                 resp_keep;

    // ---------------- run state ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= STOPPED;
        end else begin
            state_reg <= state_next;
        end
    end

    // redirect has priority over stop
    always_comb begin
        state_next = state_reg;
        if (redirect) begin
            state_next = RUNNING;
        end else if (stop) begin
            state_next = STOPPED;
        end
    end

    // ---------------- credit check ----------------
    // Slots not yet spoken for: FIFO depth minus words held minus responses
    // still expected to land in the FIFO. Discards will never occupy a slot.
    assign free = FREE_W'(FIFO_DEPTH) - FREE_W'(occ)
                - (FREE_W'(pending) - FREE_W'(discard));

    assign credit_ok = (free != '0);
    assign below_max = (FREE_W'(pending) < FREE_W'(MAX_OUTSTANDING));

    assign mem_req_valid = (state_reg == RUNNING) && !redirect && credit_ok && below_max;
    assign handshake     = mem_req_valid && mem_req_ready;

    // ---------------- address register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (redirect) begin
            addr_reg <= redirect_addr;
        end else if (handshake) begin
            addr_reg <= addr_reg + ADDR_BITS'(1);
        end
    end

    assign mem_req_addr = addr_reg;

    // ---------------- response steering ----------------
    // A response is stale if it belongs to a fetch issued before a redirect,
    // either an earlier one (discard > 0) or the one happening right now.
    assign resp_keep      = mem_resp_valid && !redirect && (discard == '0);
    assign fifo_add       = resp_keep;
    assign fifo_new_entry = mem_resp_data;
    assign fifo_clear     = reset || redirect;
    assign occupancy      = occ;

    // Everything still in flight after this cycle's response becomes a discard.
    assign discard_load = pending - PEND_W'(mem_resp_valid);

    // ---------------- counters ----------------
    updown_counter #(.WIDTH(OCC_W)) u_occ (
        .clk        (clk),
        .reset      (reset),
        .inc        (resp_keep),
        .dec        (fifo_remove && !redirect),
        .load       (redirect),
        .load_value ('0),
        .count      (occ)
    );

    updown_counter #(.WIDTH(PEND_W)) u_pending (
        .clk        (clk),
        .reset      (reset),
        .inc        (handshake),
        .dec        (mem_resp_valid),
        .load       (1'b0),
        .load_value ('0),
        .count      (pending)
    );

    updown_counter #(.WIDTH(PEND_W)) u_discard (
        .clk        (clk),
        .reset      (reset),
        .inc        (1'b0),
        .dec        (mem_resp_valid && (discard != '0)),
        .load       (redirect),
        .load_value (discard_load),
        .count      (discard)
    );

endmodule

// File: tb/tb_prefetch_feeder.sv
module tb_prefetch_feeder;
    import prefetch_feeder_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 3;
    localparam int MAXO  = 2;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          stop = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;
    logic          fifo_add;
    logic [DW-1:0] fifo_new_entry;
    logic          fifo_remove = 1'b0;
    logic          fifo_clear;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    prefetch_feeder #(
        .ADDR_BITS       (AW),
        .DATA_BITS       (DW),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .stop           (stop),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .fifo_add       (fifo_add),
        .fifo_new_entry (fifo_new_entry),
        .fifo_remove    (fifo_remove),
        .fifo_clear     (fifo_clear),
        .occupancy      (occupancy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    mreq_t         mq[$];        // memory: accepted requests awaiting response
    logic [DW-1:0] exp_q[$];     // scoreboard: words expected at fifo_add
    logic [AW-1:0] acc_addrs[$]; // addresses accepted in the current scenario

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int lat      = 1;
    int req_cnt  = 0;
    int add_cnt  = 0;
    logic [DW-1:0] first_add_data = '0;

    // reference model of the feeder
    bit            run_m  = 0;
    int            occ_m  = 0;
    int            pend_m = 0;
    int            disc_m = 0;
    logic [AW-1:0] addr_m = '0;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_acc(input string tag, input int idx, input logic [AW-1:0] exp);
        if (idx < acc_addrs.size()) check_val(tag, acc_addrs[idx], exp);
        else                        check_val({tag, "_missing"}, acc_addrs.size(), idx + 1);
    endtask

    task automatic mem_drive();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = data_of(mq[0].addr);
            void'(mq.pop_front());
        end
    endtask

    task automatic monitor();
        int free_m;
        bit exp_valid, hs, resp, exp_add;
        free_m    = DEPTH - occ_m - (pend_m - disc_m);
        exp_valid = run_m && !redirect && free_m > 0 && pend_m < MAXO;
        check_val("req_valid", mem_req_valid, exp_valid);
        if (exp_valid) check_val("req_addr", mem_req_addr, addr_m);
        check_val("clear", fifo_clear, redirect);
        check_val("occupancy", occupancy, occ_m);
        check_val("occ_bound", occupancy <= DEPTH, 1);
        resp = mem_resp_valid;
        if (resp) check_val("resp_has_pending", pend_m > 0, 1);
        exp_add = resp && !(disc_m > 0 || redirect);
        check_val("fifo_add", fifo_add, exp_add);
        if (fifo_add && exp_add) begin
            check_val("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_val("add_data", fifo_new_entry, exp_q.pop_front());
            if (add_cnt == 0) first_add_data = fifo_new_entry;
            add_cnt++;
            $display("cyc %0d add  data=0x%04h", cyc, fifo_new_entry);
        end
        hs = mem_req_valid && mem_req_ready;
        if (hs) begin
            mq.push_back('{mem_req_addr, cyc + lat});
            exp_q.push_back(data_of(addr_m));
            acc_addrs.push_back(mem_req_addr);
            req_cnt++;
            $display("cyc %0d req  addr=0x%04h", cyc, mem_req_addr);
        end
        if (redirect) begin
            addr_m = redirect_addr;
            occ_m  = 0;
            disc_m = pend_m - int'(resp);
            exp_q.delete();
        end else begin
            if (hs) addr_m = addr_m + 16'd1;
            occ_m = occ_m + int'(exp_add) - int'(fifo_remove);
            if (resp && disc_m > 0) disc_m--;
        end
        pend_m = pend_m + int'(hs) - int'(resp);
        if (redirect)  run_m = 1;
        else if (stop) run_m = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        mem_drive();
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && mq.size() > 0; i++) cycle();
        check_val("drain", mq.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; stop = 1'b0; fifo_remove = 1'b0;
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        mq.delete(); exp_q.delete(); acc_addrs.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_req_valid", mem_req_valid, 0);
        check_val("rst_req_addr", mem_req_addr, 0);
        check_val("rst_fifo_add", fifo_add, 0);
        check_val("rst_clear", fifo_clear, 1);
        check_val("rst_occupancy", occupancy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_m = 0; occ_m = 0; pend_m = 0; disc_m = 0; addr_m = '0;
        req_cnt = 0; add_cnt = 0;
    endtask

    task automatic start(input logic [AW-1:0] a);
        redirect = 1'b1; redirect_addr = a;
        cycle();
        redirect = 1'b0;
    endtask

    initial begin
        bit fired;

        // fill the FIFO from 0x0100 with 1-cycle latency
        do_reset(); lat = 1;
        start(16'h0100);
        repeat (10) cycle();
        check_val("s1_reqs", req_cnt, 3);
        check_val("s1_adds", add_cnt, 3);
        check_val("s1_occ", occupancy, 3);
        check_val("s1_valid_low", mem_req_valid, 0);
        check_acc("s1_addr0", 0, 16'h0100);
        check_acc("s1_addr2", 2, 16'h0102);

        // one remove frees exactly one slot
        fifo_remove = 1'b1; cycle(); fifo_remove = 1'b0;
        repeat (8) cycle();
        check_val("s2_reqs", req_cnt, 4);
        check_acc("s2_addr3", 3, 16'h0103);
        check_val("s2_occ", occupancy, 3);

        // latency 4: outstanding cap of 2
        drain(); do_reset(); lat = 4;
        start(16'h0400);
        repeat (5) cycle();
        check_val("s3_window_reqs", req_cnt, 2);
        repeat (20) cycle();
        check_val("s3_reqs", req_cnt, 3);
        check_val("s3_occ", occupancy, 3);

        // redirect on the cycle the first response returns
        drain(); do_reset(); lat = 2;
        start(16'h1000);
        fired = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            mem_drive();
            if (mem_resp_valid) begin
                redirect = 1'b1; redirect_addr = 16'h2000; fired = 1;
            end
            tick();
            redirect = 1'b0;
        end
        check_val("s4_fired", fired, 1);
        check_val("s4_adds_before", add_cnt, 0);
        repeat (12) cycle();
        check_acc("s4_addr_after", 2, 16'h2000);
        check_val("s4_first_add", first_add_data, data_of(16'h2000));
        check_val("s4_occ", occupancy, 3);

        // address wrap
        drain(); do_reset(); lat = 1;
        start(16'hFFFF);
        repeat (8) cycle();
        check_acc("s5_addr0", 0, 16'hFFFF);
        check_acc("s5_addr1", 1, 16'h0000);
        check_acc("s5_addr2", 2, 16'h0001);

        // stop with one request in flight
        drain(); do_reset(); lat = 3;
        start(16'h0300);
        cycle();
        stop = 1'b1; mem_req_ready = 1'b0; cycle();
        stop = 1'b0; mem_req_ready = 1'b1;
        repeat (10) cycle();
        check_val("s6_reqs", req_cnt, 1);
        check_val("s6_occ", occupancy, 1);
        check_val("s6_valid_low", mem_req_valid, 0);
        start(16'h0500);
        repeat (3) cycle();
        check_acc("s6_restart_addr", 1, 16'h0500);
        drain();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/prefetch_feeder.md
# prefetch_feeder

Write-side companion to the CPU's small prefetch FIFOs: issues sequential word reads over a valid/ready request channel and an in-order response channel, and pushes each returned word into the downstream FIFO through its `add`/`new_entry` port. Credit accounting guarantees a response never arrives without a free slot, so `add` is never raised into a full FIFO. Sits between the memory interface and the instruction/operand FIFO; redirects (jumps) flush in-flight data.

## Interface
- `ADDR_BITS`, 16, word address width
- `DATA_BITS`, 16, entry width; equals downstream FIFO `BITS`
- `FIFO_DEPTH`, 3, downstream FIFO depth; equals its `DEPTH`
- `MAX_OUTSTANDING`, 2, max accepted-but-unanswered requests; ≥1
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `redirect`  in  1  load `redirect_addr`, discard in-flight data, enter RUNNING
- `redirect_addr`  in  ADDR_BITS  new fetch address
- `stop`  in  1  enter STOPPED; no new requests
- `mem_req_valid`  out  1  request pending
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  ADDR_BITS  registered fetch address
- `mem_resp_valid`  in  1  response word present; in order, ≥1 cycle after acceptance
- `mem_resp_data`  in  DATA_BITS  response word
- `fifo_add`  out  1  drives FIFO `add`
- `fifo_new_entry`  out  DATA_BITS  drives FIFO `new_entry`
- `fifo_remove`  in  1  copy of consumer's FIFO `remove`
- `fifo_clear`  out  1  drives FIFO reset; `reset | redirect`
- `occupancy`  out  clog2(FIFO_DEPTH+1)  words currently in FIFO

## Operation
- States: STOPPED, RUNNING; shared enum. Reset → STOPPED.
- STOPPED → RUNNING on `redirect`; RUNNING → STOPPED on `stop` unless `redirect` the same cycle (`redirect` wins). `redirect` in RUNNING stays RUNNING.
- Counters: `occ` (words in FIFO), `pending` (accepted, unanswered, 0..MAX_OUTSTANDING), `discard` (pending responses to drop, ≤ `pending`).
- `free = FIFO_DEPTH − occ − (pending − discard)`; computed at NE width + 1, never negative by construction.
- `mem_req_valid = RUNNING & !redirect & free > 0 & pending < MAX_OUTSTANDING`.
- Handshake (`mem_req_valid & mem_req_ready`): `pending++`, `mem_req_addr++` mod 2^ADDR_BITS (wraps to 0).
- Response: `pending--`. If `discard > 0` or `redirect` this cycle: dropped, `discard--` when `discard > 0`. Else `fifo_add = 1`, `fifo_new_entry = mem_resp_data` (combinational, same cycle), `occ++`.
- `fifo_remove`: `occ--`. Issued only when FIFO last entry is valid; simultaneous add and remove leaves `occ` unchanged.
- `redirect`: `mem_req_addr ← redirect_addr`; `occ ← 0`; `discard ← pending − resp_this_cycle` (all in-flight become discards); `fifo_remove` ignored.
- `stop` does not cancel outstanding requests; their responses are still delivered.
- `mem_resp_valid` with `pending == 0` is a protocol violation; behaviour undefined, bench asserts against it.

## Timing
- Reset values: STOPPED, `mem_req_valid` 0, `mem_req_addr` 0, `fifo_add` 0, `fifo_clear` 1, `occupancy` 0, `pending` 0, `discard` 0.
- First request: cycle after `redirect` at `redirect_addr`.
- Back-to-back requests: one per cycle while `mem_req_ready` high and credits remain.
- Response to `fifo_add`: 0 cycles. Request acceptance to `occupancy` increment: response latency + 1.
- `reset` mid-operation: all counters cleared next edge; late responses after reset are a protocol violation (memory is reset together).

## Structure
- Shared package: state enum (STOPPED, RUNNING); width helper for `clog2(FIFO_DEPTH+1)`.
- One sub-module, `updown_counter` (inc, dec, load, load value, WIDTH), instantiated for `occ`, `pending`, `discard`.
- Top level holds the state register, address register, credit compare, and response steering.

## Test plan
- Reset, `redirect` with addr 0x0100, `mem_req_ready` = 1, 1-cycle response latency, no removes → exactly 3 requests (0x0100–0x0102), 3 `fifo_add`, `occupancy` = 3, `mem_req_valid` then 0.
- Same, then `fifo_remove` once → one new request at 0x0103, `occupancy` returns to 3; never > FIFO_DEPTH.
- `mem_req_ready` = 1, response latency 4 → `pending` caps at 2; `mem_req_valid` low while `pending` = 2.
- Two requests in flight, `redirect` to 0x2000 on the cycle the first response arrives → both responses dropped, no `fifo_add`, `fifo_clear` pulses 1 cycle, next request at 0x2000, next `fifo_add` carries 0x2000's data.
- `redirect` to 0xFFFF, free run → addresses 0xFFFF, 0x0000, 0x0001.
- `stop` with 1 request in flight → response still added, `occupancy` +1, no further requests until the next `redirect`.
